input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 106 ++++++++++
 tb/tb_input_debouncer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Pushbutton and slide-switch front end: 2-flop synchronizers, per-bit
// N-cycle debounce, and per-key press counters packed into the core's PIO words.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_n,
    input  logic [17:0] sw,
    output logic [31:0] keysport_export,
    output logic [31:0] swport_export,
    output logic [3:0]  key_press_pulse
);

    localparam int NUM_KEYS = 4;
    localparam int NUM_SW   = 18;
    localparam int NUM_BITS = NUM_KEYS + NUM_SW;
    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_meta;
    logic [NUM_KEYS-1:0] key_sync;
    logic [NUM_SW-1:0]   sw_meta;
    logic [NUM_SW-1:0]   sw_sync;

    // Keys reset to the released (high) raw level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            // NOTE: non-blocking, so each flop captures its predecessor's old value
            // and the chain really is two stages deep.
            key_meta <= key_n;
            key_sync <= key_meta;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    // Bits [3:0] are keys (1 = pressed), bits [21:4] are switches.
    logic [NUM_BITS-1:0] level;
    assign level = {sw_sync, ~key_sync};

    logic [NUM_BITS-1:0] stable;
    logic [NUM_BITS-1:0] differ;
    logic [NUM_BITS-1:0] settled;
    logic [CNT_W-1:0]    cnt [NUM_BITS];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a bit unassigned and no latch is inferred.
        differ  = level ^ stable;
        settled = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            settled[i] = differ[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            // NOTE: the counter array is reset too; a surviving count would let a
            // half-debounced transition complete early after reset.
            for (int i = 0; i < NUM_BITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable ^ settled;
            for (int i = 0; i < NUM_BITS; i++) begin
                if (!differ[i] || settled[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press is a key settling to the pressed level; releases are ignored.
    logic [NUM_KEYS-1:0] press;
    assign press = settled[NUM_KEYS-1:0] & level[NUM_KEYS-1:0];

    logic [3:0] press_cnt [NUM_KEYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_press_pulse <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                press_cnt[k] <= '0;
            end
        end else begin
            key_press_pulse <= press;
            for (int k = 0; k < NUM_KEYS; k++) begin
                press_cnt[k] <= press_cnt[k] + 4'(press[k]);
            end
        end
    end

    assign keysport_export = {8'h00, press_cnt[3], press_cnt[2], press_cnt[1],
                              press_cnt[0], 4'h0, stable[NUM_KEYS-1:0]};
    assign swport_export   = {14'h0000, stable[NUM_BITS-1:NUM_KEYS]};

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with a 4-cycle window: a sliding-
// window reference model compared every cycle, plus directed literal checks.
module tb_input_debouncer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_n = 4'hF;
    logic [17:0] sw = '0;
    logic [31:0] keysport_export;
    logic [31:0] swport_export;
    logic [3:0]  key_press_pulse;

    int checks = 0;
    int errors = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_n           (key_n),
        .sw              (sw),
        .keysport_export (keysport_export),
        .swport_export   (swport_export),
        .key_press_pulse (key_press_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit's debounced level flips once the input sampled on
    // the N edges ending two edges ago all disagree with it (two synchronizer
    // stages in front). hist[0] is the oldest sample.
    logic [21:0] hist [N+1];
    logic [21:0] m_stable = '0;
    logic [3:0]  m_press [4];
    logic [3:0]  m_pulse = '0;
    logic        model_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [21:0] cur;
        logic [21:0] flip;
        logic [3:0]  rise;
        if (!rst_n) begin
            m_stable    <= '0;
            m_pulse     <= '0;
            model_valid <= 1'b1;
            for (int j = 0; j <= N; j++) hist[j] <= '0;
            for (int k = 0; k < 4; k++) m_press[k] <= '0;
        end else begin
            cur  = {sw, ~key_n};
            flip = '1;
            for (int j = 0; j < N; j++) flip &= hist[j] ^ m_stable;
            rise = flip[3:0] & ~m_stable[3:0];
            m_stable <= m_stable ^ flip;
            m_pulse  <= rise;
            for (int k = 0; k < 4; k++) m_press[k] <= m_press[k] + 4'(rise[k]);
            for (int j = 0; j < N; j++) hist[j] <= hist[j+1];
            hist[N] <= cur;
        end
    end

    function automatic logic [31:0] model_keys();
        return {8'h00, m_press[3], m_press[2], m_press[1], m_press[0], 4'h0, m_stable[3:0]};
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_keys", keysport_export, model_keys());
            check("model_sw", swport_export, {14'h0, m_stable[21:4]});
            check("model_pulse", {28'h0, key_press_pulse}, {28'h0, m_pulse});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Enter reset (asynchronously, mid-cycle) with the given key level held.
    task automatic do_reset(input logic [3:0] kn);
        rst_n = 1'b0;
        key_n = kn;
        sw    = '0;
        #1;
        check("rst_async_keys", keysport_export, 32'h0);
        check("rst_async_sw", swport_export, 32'h0);
        steps(2);
        check("rst_hold_pulse", {28'h0, key_press_pulse}, 32'h0);
        rst_n = 1'b1;
    endtask

    int pulses;

    initial begin
        steps(2);
        do_reset(4'hF);

        // Clean switch word change: visible on edge 6, not edge 5.
        sw = 18'h2_A5A5;
        steps(5);
        check("sw_edge5", swport_export, 32'h0);
        step();
        check("sw_edge6", swport_export, 32'h0002_A5A5);
        check("sw_keys_idle", keysport_export, 32'h0);
        sw = '0;
        steps(8);
        check("sw_cleared", swport_export, 32'h0);

        // Three-cycle glitch on key 0 is rejected.
        key_n = 4'b1110;
        steps(3);
        key_n = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("glitch_keys", keysport_export, 32'h0);
            check("glitch_pulse", {28'h0, key_press_pulse}, 32'h0);
        end

        // Key 2 press: level bit 2 and counter nibble [19:16], one pulse.
        do_reset(4'hF);
        key_n = 4'b1011;
        steps(5);
        check("k2_edge5", keysport_export, 32'h0);
        step();
        check("k2_edge6", keysport_export, 32'h0001_0004);
        check("k2_pulse", {28'h0, key_press_pulse}, 32'h4);
        step();
        check("k2_pulse_once", {28'h0, key_press_pulse}, 32'h0);
        steps(3);
        key_n = 4'hF;
        steps(5);
        check("k2_rel_edge5", keysport_export, 32'h0001_0004);
        step();
        check("k2_rel_edge6", keysport_export, 32'h0001_0000);
        check("k2_rel_nopulse", {28'h0, key_press_pulse}, 32'h0);

        // Key 3 pressed sixteen times: counter wraps 15 -> 0.
        do_reset(4'hF);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            key_n = 4'b0111;
            for (int c = 0; c < 8; c++) begin
                step();
                pulses += int'(key_press_pulse[3]);
            end
            check("k3_count_pressed", keysport_export, (32'((i + 1) % 16) << 20) | 32'h8);
            key_n = 4'hF;
            for (int c = 0; c < 8; c++) begin
                step();
                pulses += int'(key_press_pulse[3]);
            end
            check("k3_count_released", keysport_export, 32'((i + 1) % 16) << 20);
        end
        check("k3_pulses", 32'(pulses), 32'd16);

        // All four keys pressed together.
        do_reset(4'hF);
        key_n = 4'h0;
        steps(5);
        check("all_edge5", keysport_export, 32'h0);
        step();
        check("all_edge6", keysport_export, 32'h0011_110F);
        check("all_pulse", {28'h0, key_press_pulse}, 32'hF);
        step();
        check("all_pulse_once", {28'h0, key_press_pulse}, 32'h0);

        // Key 1 held through reset counts as one press after release.
        do_reset(4'b1101);
        steps(5);
        check("held_edge5", keysport_export, 32'h0);
        step();
        check("held_edge6", keysport_export, 32'h0000_1002);
        check("held_pulse", {28'h0, key_press_pulse}, 32'h2);

        // Reset in the middle of a switch debounce discards it.
        sw = 18'h0_0001;
        steps(3);
        rst_n = 1'b0;
        key_n = 4'hF;
        #1;
        check("mid_rst_keys", keysport_export, 32'h0);
        check("mid_rst_sw", swport_export, 32'h0);
        steps(2);
        rst_n = 1'b1;
        steps(5);
        check("mid_rel_edge5", swport_export, 32'h0);
        step();
        check("mid_rel_edge6", swport_export, 32'h0000_0001);

        steps(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
